video_timing_gen: RTL and testbench

Raster timing generator that drives the shared video interface consumed by all on-screen objects (paddles, ball, scoreboards, game-over overlay). It counts pixels and lines on `pixel_clk` and emits the signed `hpos`/`vpos` coordinates, `active`, the one-cycle `fsync` frame strobe, and HDMI `hsync`/`vsync` for the TMDS encoder. Default timing is 1280x720p60 with a 74.25 MHz pixel clock.

---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/sync_axis_counter.sv | 68 ++++++
 rtl/video_timing_gen.sv | 113 +++++++++++
 tb/tb_video_timing_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster constants and coordinate type.
// Used by the timing generator, hdmi_transmit and all game objects.
package video_timing_pkg;

    localparam int unsigned HRES   = 1280;
    localparam int unsigned H_FP   = 110;
    localparam int unsigned H_SYNC = 40;
    localparam int unsigned H_BP   = 220;
    localparam int unsigned VRES   = 720;
    localparam int unsigned V_FP   = 5;
    localparam int unsigned V_SYNC = 5;
    localparam int unsigned V_BP   = 20;

    localparam int unsigned H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int unsigned H_TOTAL = H_BLANK + HRES;
    localparam int unsigned V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int unsigned V_TOTAL = V_BLANK + VRES;

    typedef logic signed [11:0] coord_t;
    typedef logic [10:0]        cnt_t;

    // Raw counter to screen coordinate; blanking maps to negatives.
    function automatic coord_t cnt_to_pos(cnt_t cnt, int unsigned blank);
        return coord_t'({1'b0, cnt}) - coord_t'(blank);
    endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One raster axis: wrapping counter plus registered position/sync decode.
// Ports: adv_in (pipeline enable), tick_in/wrap_out, pos, sync, first.
module sync_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned TOTAL = H_TOTAL,
    parameter int unsigned FP    = H_FP,
    parameter int unsigned SYNC  = H_SYNC,
    parameter int unsigned BP    = H_BP,
    parameter logic        POL   = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   adv_in,
    input  logic   tick_in,
    output logic   wrap_out,
    output coord_t pos,
    output logic   sync,
    output logic   first
);

    localparam int unsigned BLANK   = FP + SYNC + BP;
    localparam cnt_t        CNT_MAX = cnt_t'(TOTAL - 1);
    localparam cnt_t        SYNC_LO = cnt_t'(FP);
    localparam cnt_t        SYNC_HI = cnt_t'(FP + SYNC - 1);

    cnt_t   cnt_q, cnt_d;
    coord_t pos_q, pos_d;
    logic   sync_q, sync_d;
    logic   first_q, first_d;

    // Counter steps on tick_in; the decode stage samples the count on
    // every advancing cycle so outputs trail the counter by one cycle.
    always_comb begin
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        sync_d   = sync_q;
        first_d  = first_q;
        wrap_out = tick_in && (cnt_q == CNT_MAX);
        if (tick_in) begin
            cnt_d = wrap_out ? '0 : cnt_q + 1'b1;
        end
        if (adv_in) begin
            pos_d   = cnt_to_pos(cnt_q, BLANK);
            sync_d  = (cnt_q >= SYNC_LO && cnt_q <= SYNC_HI) ? POL : ~POL;
            first_d = (cnt_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pos_q   <= cnt_to_pos(cnt_t'(0), BLANK);
            sync_q  <= ~POL;
            first_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            sync_q  <= sync_d;
            first_q <= first_d;
        end
    end

    assign pos   = pos_q;
    assign sync  = sync_q;
    assign first = first_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: hpos/vpos, active, fsync/lsync, h/vsync.
// Ports: pixel_clk, rst_n (sync), en (freeze), frame_cnt (wraps 2^16).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned HRES     = video_timing_pkg::HRES,
    parameter int unsigned H_FP     = video_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = video_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = video_timing_pkg::H_BP,
    parameter int unsigned VRES     = video_timing_pkg::VRES,
    parameter int unsigned V_FP     = video_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = video_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = video_timing_pkg::V_BP,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        en,
    output coord_t      hpos,
    output coord_t      vpos,
    output logic        active,
    output logic        fsync,
    output logic        lsync,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] frame_cnt
);

    localparam int unsigned H_TOT = H_FP + H_SYNC + H_BP + HRES;
    localparam int unsigned V_TOT = V_FP + V_SYNC + V_BP + VRES;

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        HRES < 1 || VRES < 1 ||
        H_TOT > 2047 || V_TOT > 2047) begin : g_bad_params
        $error("video_timing_gen: illegal timing parameters");
    end

    logic        run_q, run_d;
    logic        wrap_q, wrap_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        adv;
    logic        h_wrap, v_wrap;
    logic        h_first, v_first;

    // The first enabled cycle after reset only arms the pipeline, so the
    // reset outputs persist one edge and fsync lands on the second edge.
    assign adv = en && run_q;

    sync_axis_counter #(
        .TOTAL (H_TOT),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .POL   (SYNC_POL)
    ) u_h (
        .clk      (pixel_clk),
        .rst_n    (rst_n),
        .adv_in   (adv),
        .tick_in  (adv),
        .wrap_out (h_wrap),
        .pos      (hpos),
        .sync     (hsync),
        .first    (h_first)
    );

    sync_axis_counter #(
        .TOTAL (V_TOT),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .POL   (SYNC_POL)
    ) u_v (
        .clk      (pixel_clk),
        .rst_n    (rst_n),
        .adv_in   (adv),
        .tick_in  (h_wrap),
        .wrap_out (v_wrap),
        .pos      (vpos),
        .sync     (vsync),
        .first    (v_first)
    );

    // v_wrap implies h_wrap; delay it one stage so frame_cnt steps
    // on the same edge that presents fsync.
    always_comb begin
        run_d       = run_q | en;
        wrap_d      = wrap_q;
        frame_cnt_d = frame_cnt_q;
        if (adv) begin
            wrap_d      = v_wrap;
            frame_cnt_d = frame_cnt_q + {15'd0, wrap_q};
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            wrap_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            run_q       <= run_d;
            wrap_q      <= wrap_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign lsync     = h_first;
    assign fsync     = h_first && v_first;
    assign active    = !hpos[11] && !vpos[11];
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 720p instance for line timing, and a
// shrunken raster (25x15, 375-cycle frame) for frame-level behaviour.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;

    coord_t      d_hpos, d_vpos;
    logic        d_active, d_fsync, d_lsync, d_hsync, d_vsync;
    logic [15:0] d_frame_cnt;

    coord_t      s_hpos, s_vpos;
    logic        s_active, s_fsync, s_lsync, s_hsync, s_vsync;
    logic [15:0] s_frame_cnt;

    int nvec = 0;
    int nerr = 0;

    video_timing_gen u_def (
        .pixel_clk (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hpos      (d_hpos),
        .vpos      (d_vpos),
        .active    (d_active),
        .fsync     (d_fsync),
        .lsync     (d_lsync),
        .hsync     (d_hsync),
        .vsync     (d_vsync),
        .frame_cnt (d_frame_cnt)
    );

    // H: 3+2+4 blank + 16 = 25; V: 2+2+3 blank + 8 = 15.
    video_timing_gen #(
        .HRES     (16),
        .H_FP     (3),
        .H_SYNC   (2),
        .H_BP     (4),
        .VRES     (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .SYNC_POL (1'b1)
    ) u_small (
        .pixel_clk (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hpos      (s_hpos),
        .vpos      (s_vpos),
        .active    (s_active),
        .fsync     (s_fsync),
        .lsync     (s_lsync),
        .hsync     (s_hsync),
        .vsync     (s_vsync),
        .frame_cnt (s_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int hs_cnt, hs_first, d_ls_extra;
    int s_fs_n, s_fs_last, s_act0, s_act1, s_vs0, s_hs0;
    int bad, n, act;

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;

        repeat (5) begin
            @(negedge clk);
            chk("rst_d_hpos", d_hpos, -370);
            chk("rst_d_vpos", d_vpos, -30);
            chk("rst_d_active", d_active, 0);
            chk("rst_d_fsync", d_fsync, 0);
            chk("rst_d_lsync", d_lsync, 0);
            chk("rst_d_hsync", d_hsync, 0);
            chk("rst_d_vsync", d_vsync, 0);
            chk("rst_d_frame", d_frame_cnt, 0);
            chk("rst_s_hpos", s_hpos, -9);
            chk("rst_s_vpos", s_vpos, -7);
        end

        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_e1_fsync", d_fsync, 0);
        chk("rel_e1_lsync", d_lsync, 0);
        chk("rel_e1_hpos", d_hpos, -370);
        @(negedge clk);
        chk("rel_e2_fsync", d_fsync, 1);
        chk("rel_e2_lsync", d_lsync, 1);
        chk("rel_e2_s_fsync", s_fsync, 1);

        hs_cnt     = 0;
        hs_first   = -1;
        d_ls_extra = 0;
        s_fs_n     = 0;
        s_fs_last  = -1;
        s_act0     = 0;
        s_act1     = 0;
        s_vs0      = 0;
        s_hs0      = 0;

        for (int t = 0; t <= 1650; t++) begin
            if (t > 0) @(negedge clk);
            if (t < 1650 && d_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = t;
            end
            if (t > 0 && t < 1650 && d_lsync) d_ls_extra++;
            if (t == 369) chk("d_hpos_pre_act", d_hpos, -1);
            if (t == 370) chk("d_hpos_act0", d_hpos, 0);
            if (t == 1650) begin
                chk("d_line_lsync", d_lsync, 1);
                chk("d_line_hpos", d_hpos, -370);
                chk("d_line_vpos", d_vpos, -29);
            end
            if (s_fsync) begin
                if (s_fs_last >= 0)
                    chk("s_fsync_gap", t - s_fs_last, 375);
                s_fs_last = t;
                s_fs_n++;
            end
            if (s_active) begin
                if (t < 375) s_act0++;
                else if (t < 750) s_act1++;
            end
            if (t < 375 && s_vsync) s_vs0++;
            if (t < 25 && s_hsync) s_hs0++;
            if (t == 183) chk("s_pre_active", s_active, 0);
            if (t == 184) begin
                chk("s_act_rise", s_active, 1);
                chk("s_act_hpos", s_hpos, 0);
                chk("s_act_vpos", s_vpos, 0);
            end
            if (t == 374) begin
                chk("s_last_hpos", s_hpos, 15);
                chk("s_last_vpos", s_vpos, 7);
                chk("s_last_frame", s_frame_cnt, 0);
            end
            if (t == 375) begin
                chk("s_wrap_fsync", s_fsync, 1);
                chk("s_wrap_lsync", s_lsync, 1);
                chk("s_wrap_hpos", s_hpos, -9);
                chk("s_wrap_vpos", s_vpos, -7);
                chk("s_frame_1", s_frame_cnt, 1);
            end
            if (t == 750) chk("s_frame_2", s_frame_cnt, 2);
        end

        chk("d_hsync_start", hs_first, 110);
        chk("d_hsync_len", hs_cnt, 40);
        chk("d_lsync_extra", d_ls_extra, 0);
        chk("s_fsync_count", s_fs_n, 5);
        chk("s_active_f0", s_act0, 128);
        chk("s_active_f1", s_act1, 128);
        chk("s_vsync_len", s_vs0, 50);
        chk("s_hsync_len", s_hs0, 2);

        repeat (2520 - 1650) @(negedge clk);
        chk("stall_d_hpos", d_hpos, 500);
        chk("stall_s_hpos", s_hpos, 11);
        en  = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (d_hpos != 500 || d_vpos != -29 || s_hpos != 11 ||
                s_vpos != 3 || s_frame_cnt != 6 || d_lsync)
                bad++;
        end
        chk("stall_frozen", bad, 0);
        en = 1'b1;
        @(negedge clk);
        chk("resume_d_hpos", d_hpos, 501);
        chk("resume_s_hpos", s_hpos, 12);
        chk("resume_s_vpos", s_vpos, 3);
        chk("resume_s_frame", s_frame_cnt, 6);

        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_s_hpos", s_hpos, -9);
        chk("mid_rst_s_vpos", s_vpos, -7);
        chk("mid_rst_s_frame", s_frame_cnt, 0);
        chk("mid_rst_s_fsync", s_fsync, 0);
        chk("mid_rst_s_hsync", s_hsync, 0);
        chk("mid_rst_d_hpos", d_hpos, -370);
        chk("mid_rst_d_vpos", d_vpos, -30);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_e1_fsync", s_fsync, 0);
        @(negedge clk);
        chk("mid_e2_fsync", s_fsync, 1);
        chk("mid_e2_frame", s_frame_cnt, 0);

        n   = 0;
        act = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (s_active) act++;
            if (s_fsync) break;
        end
        chk("mid_frame_len", n, 375);
        chk("mid_frame_act", act, 128);
        chk("mid_frame_cnt", s_frame_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
